aes_inv_cipher: RTL and testbench

AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

---
 rtl/aes_inv_cipher.sv | 156 +++++++++++++++
 tb/tb_aes_inv_cipher.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher.sv
// AES-128 inverse cipher, iterative: one round per clock, round keys fetched
// combinationally from an external key store addressed by rk_idx.
module aes_inv_cipher #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] Indata,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] Outdata
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t       state_reg, state_next;
    logic [3:0]   rnd_reg, rnd_next;
    logic [127:0] st_reg, st_next;
    logic [127:0] out_reg, out_next;
    logic [127:0] shifted, subbed, keyed, mixed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant using the x, x^2, x^3 multiples.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    genvar gi;
    generate
        // Byte k is state[row k%4][col k/4]; row r rotates right by r.
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int R   = gi % 4;
            localparam int C   = gi / 4;
            localparam int SRC = R + 4 * ((C - R + 4) % 4);
            assign shifted[127-8*gi -: 8] = st_reg[127-8*SRC -: 8];
            InvSbox u_sbox (
                .a (shifted[127-8*gi -: 8]),
                .y (subbed[127-8*gi -: 8])
            );
        end

        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            assign a0 = keyed[127-32*gi -: 8];
            assign a1 = keyed[119-32*gi -: 8];
            assign a2 = keyed[111-32*gi -: 8];
            assign a3 = keyed[103-32*gi -: 8];
            assign mixed[127-32*gi -: 32] = {
                gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
            };
        end
    endgenerate

    assign keyed = subbed ^ rk_data;

    always_comb begin
        state_next = state_reg;
        rnd_next   = rnd_reg;
        st_next    = st_reg;
        out_next   = out_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        rk_idx     = 4'd0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                rk_idx   = 4'(NR);
                if (in_valid) begin
                    st_next    = Indata ^ rk_data;
                    rnd_next   = 4'(NR - 1);
                    state_next = ROUND;
                end
            end
            ROUND: begin
                rk_idx   = rnd_reg;
                st_next  = mixed;
                rnd_next = rnd_reg - 4'd1;
                if (rnd_reg == 4'd1) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                out_next   = keyed;
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rnd_reg   <= 4'd0;
            st_reg    <= '0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rnd_reg   <= rnd_next;
            st_reg    <= st_next;
            out_reg   <= out_next;
        end
    end

    assign Outdata = out_reg;

endmodule

// Inverse AES S-box as a 256-entry byte table; entry 0 sits in the top byte.
module InvSbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [2047:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y = TABLE[{~a, 3'b000} +: 8];

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher: a forward AES-128 model produces
// ciphertexts, the expected plaintexts are queued and checked by a monitor.
module tb_aes_inv_cipher;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] Indata = '0;
    logic [127:0] rk_data;
    logic         in_ready;
    logic [3:0]   rk_idx;
    logic         out_valid;
    logic [127:0] Outdata;

    aes_inv_cipher #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Indata    (Indata),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Outdata   (Outdata)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] pt;
        int           acc;
    } exp_t;
    exp_t q[$];

    logic [7:0]    sb [256];
    logic [1407:0] rk_all = '0;
    logic          noise_mode = 1'b0;
    logic [127:0]  noise = '0;

    always @(negedge clk) noise <= {$urandom, $urandom, $urandom, $urandom};

    // Key store: a key is only guaranteed while the DUT actually samples it.
    always_comb begin
        rk_data = '0;
        if (rk_idx <= 4'd10) rk_data = rk_all[int'(rk_idx)*128 +: 128];
        if (noise_mode && !((in_ready && in_valid) || (!in_ready && !out_valid)))
            rk_data = noise;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from its definition: GF(2^8) inverse then the affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv, r, s;
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gm(inv, 8'(v));
            end
            r = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sb[v] = s ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] o;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gm(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) o[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] rks);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[127-8*i -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[rd*128 + 127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [127:0] key, input logic [127:0] ct,
                        input logic [127:0] pt, output int acc);
        int   n;
        exp_t e;
        n = 0;
        acc = -1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_wait_in_ready", {127'd0, in_ready}, 128'd1);
            return;
        end
        rk_all   = expand(key);
        Indata   = ct;
        in_valid = 1'b1;
        e.pt     = pt;
        e.acc    = cyc + 1;
        acc      = e.acc;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 128'(q.size()), 128'd0);
    endtask

    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !prev) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", {127'd0, out_valid}, 128'd0);
                end else begin
                    e = q.pop_front();
                    check("Outdata", Outdata, e.pt);
                    check("latency", 128'(cyc - e.acc), 128'd10);
                end
            end
            prev = out_valid;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin : main
        int   acc, prev_acc, n;
        exp_t e;
        logic [127:0] key, pt;
        build_sbox();

        #2 rst_n = 1'b0;
        #1;
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_Outdata", Outdata, 128'd0);
        check("reset_rk_idx", {124'd0, rk_idx}, 128'd10);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        send(KEY_C1, CT_C1, PT_C1, acc);
        drain();
        send(KEY_B, CT_B, PT_B, acc);
        drain();

        // Backpressure with a second request held during DONE.
        out_ready = 1'b0;
        send(KEY_C1, CT_C1, PT_C1, acc);
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", {127'd0, out_valid}, 128'd1);
        rk_all   = expand(KEY_B);
        Indata   = CT_B;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold_Outdata", Outdata, PT_C1);
            check("bp_hold_in_ready", {127'd0, in_ready}, 128'd0);
            check("bp_hold_out_valid", {127'd0, out_valid}, 128'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
        check("bp_release_out_valid", {127'd0, out_valid}, 128'd0);
        check("bp_release_Outdata", Outdata, PT_C1);
        e.pt  = PT_B;
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        check("bp_second_accepted", {127'd0, in_ready}, 128'd0);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset while rnd = 5.
        send(KEY_C1, CT_C1, PT_C1, acc);
        n = 0;
        while (rk_idx != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_rnd5_reached", {124'd0, rk_idx}, 128'd5);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        check("mid_reset_in_ready", {127'd0, in_ready}, 128'd1);
        check("mid_reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("mid_reset_Outdata", Outdata, 128'd0);
        check("mid_reset_rk_idx", {124'd0, rk_idx}, 128'd10);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(KEY_C1, CT_C1, PT_C1, acc);
        drain();

        // Back-to-back random blocks with noise on unsampled key cycles.
        noise_mode = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 100; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            send(key, encrypt(pt, expand(key)), pt, acc);
            if (i > 0) check("accept_spacing", 128'(acc - prev_acc), 128'd12);
            prev_acc = acc;
        end
        drain();
        noise_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
